// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle, XLEN+2 edges from accept to valid, 2 for div-by-zero/overflow.
// Backpressure: ready is high only in IDLE; start while busy is dropped; flush aborts from any state.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] res
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          func_q, func_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;

    // Operand conditioning, evaluated in PREP from the raw operands latched at accept.
    logic            sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    assign sgn1 = (func_q == 3'd1) || (func_q == 3'd2) || (func_q == 3'd4) || (func_q == 3'd6);
    assign sgn2 = (func_q == 3'd1) || (func_q == 3'd4) || (func_q == 3'd6);
    assign neg1 = sgn1 & a_q[XLEN-1];
    assign neg2 = sgn2 & b_q[XLEN-1];
    assign mag1 = neg1 ? -a_q : a_q;
    assign mag2 = neg2 ? -b_q : b_q;

    assign div_zero = (b_q == '0);
    assign div_ovf  = ((func_q == 3'd4) || (func_q == 3'd6)) && (a_q == MIN_NEG) && (b_q == '1);
    assign fast     = func_q[2] && (div_zero || div_ovf);
    // func[1] separates REM/REMU from DIV/DIVU within the divide group.
    assign fast_res = div_zero ? (func_q[1] ? a_q : '1)
                               : (func_q[1] ? '0 : a_q);

    // acc holds {hi, lo}: product {hi,lo} for multiply, {remainder, quotient} for divide.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] iter_acc;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign iter_acc  = func_q[2] ? div_next : mul_next;

    // Sign fix-up applied to the accumulator value produced by the final iteration.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, fin_res;

    assign prod_fix = neg_q ? -iter_acc : iter_acc;
    assign div_raw  = func_q[1] ? iter_acc[2*XLEN-1:XLEN] : iter_acc[XLEN-1:0];
    assign div_fix  = neg_q ? -div_raw : div_raw;
    assign fin_res  = func_q[2] ? div_fix
                    : ((func_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    func_d  = func;
                    a_d     = op1;
                    b_d     = op2;
                    state_d = PREP;
                end
            end
            PREP: begin
                acc_d = {{XLEN{1'b0}}, mag1};
                b_d   = mag2;
                neg_d = (func_q == 3'd6) ? neg1 : (neg1 ^ neg2);
                cnt_d = '0;
                if (fast) begin
                    res_d   = fast_res;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    res_d   = fin_res;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a start in IDLE; the pending result is discarded.
        if (flush) begin
            state_d = IDLE;
            func_d  = func_q;
            a_d     = a_q;
            b_d     = b_q;
            cnt_d   = '0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            func_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign valid = (state_q == DONE);
    assign res   = res_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (XLEN=32): vector table plus flush, busy-start and async-reset sequences.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func;
    logic [31:0] op1, op2;
    logic        flush;
    logic        ready, valid;
    logic [31:0] res;

    int total = 0;
    int bad   = 0;

    muldiv_iter #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .func (func),
        .op1  (op1),
        .op2  (op2),
        .flush(flush),
        .ready(ready),
        .valid(valid),
        .res  (res)
    );

    always #5 clk = ~clk;

    localparam int LAT_N = 33;  // posedges after the accepting edge until valid is seen
    localparam int LAT_F = 1;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, watch for the valid pulse and check latency, result and handshake.
    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int   edges;
        logic got;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; func = f; op1 = a; op2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op1 = $urandom; op2 = $urandom;
        busy_ok = !ready && !valid;
        edges = 0;
        got   = 1'b0;
        while (edges < 60 && !got) begin
            @(posedge clk);
            edges++;
            #1;
            if (valid) got = 1'b1;
            else if (ready) busy_ok = 1'b0;
        end
        check({nm, " latency"}, 64'(edges), 64'(lat));
        check({nm, " busy"}, {63'b0, busy_ok}, 64'd1);
        check({nm, " res"}, {32'b0, res}, {32'b0, exp});
        @(posedge clk);
        #1;
        check({nm, " ready after"}, {62'b0, ready, valid}, 64'd2);
        check({nm, " res held"}, {32'b0, res}, {32'b0, exp});
    endtask

    initial begin
        int npulse;
        int hold;

        vq.push_back('{3'd0, 32'd7,        32'd6,        32'd42,       LAT_N});
        vq.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_N});
        vq.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_N});
        vq.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_N});
        vq.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_N});
        vq.push_back('{3'd0, 32'h12345678, 32'h10,       32'h23456780, LAT_N});
        vq.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_N});
        vq.push_back('{3'd1, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, LAT_N});
        vq.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_N});
        vq.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_N});
        vq.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       LAT_N});
        vq.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        LAT_N});
        vq.push_back('{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_N});
        vq.push_back('{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        LAT_N});
        vq.push_back('{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LAT_N});
        vq.push_back('{3'd7, 32'h80000000, 32'd3,        32'd2,        LAT_N});
        vq.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_N});
        vq.push_back('{3'd4, 32'h80000000, 32'd1,        32'h80000000, LAT_N});
        vq.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_F});
        vq.push_back('{3'd6, 32'd5,        32'd0,        32'd5,        LAT_F});
        vq.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_F});
        vq.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_F});
        vq.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_F});
        vq.push_back('{3'd7, 32'd9,        32'd0,        32'd9,        LAT_F});

        rst = 1'b1; start = 1'b0; flush = 1'b0; func = '0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {31'b0, ready, valid, res}, {31'b0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++)
            do_op($sformatf("vec%0d f%0d", i, vq[i].f), vq[i].f, vq[i].a, vq[i].b, vq[i].exp, vq[i].lat);

        // Flush at CALC iteration 10: back to IDLE, no pulse, previous result kept (9 from REMU 9/0).
        @(negedge clk);
        start = 1'b1; func = 3'd4; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush idle", {62'b0, ready, valid}, 64'd2);
        check("flush res kept", {32'b0, res}, 64'd9);
        npulse = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) npulse++;
        end
        check("flush no pulse", 64'(npulse), 64'd0);

        // Flush together with start in IDLE drops the start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func = 3'd0; op1 = 32'd2; op2 = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush beats start", {63'b0, ready}, 64'd1);
        npulse = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) npulse++;
        end
        check("dropped start no pulse", 64'(npulse), 64'd0);

        // Start pulsed while busy is ignored.
        @(negedge clk);
        start = 1'b1; func = 3'd5; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; func = 3'd0; op1 = 32'd2; op2 = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        npulse = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (valid) npulse++;
        end
        check("busy start pulses", 64'(npulse), 64'd1);
        check("busy start res", {32'b0, res}, 64'd14);

        // Asynchronous reset mid-CALC clears outputs before the next edge.
        @(negedge clk);
        start = 1'b1; func = 3'd0; op1 = 32'd5; op2 = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async reset", {31'b0, ready, valid, res}, {31'b0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        hold = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) hold++;
        end
        check("no pulse after reset", 64'(hold), 64'd0);
        do_op("mul 3x3 after reset", 3'd0, 32'd3, 32'd3, 32'd9, LAT_N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
